// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor. Carry propagation is split into
// STAGES registered chunks of WIDTH/STAGES bits, and a valid bit travels with each chunk.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int C = WIDTH / STAGES;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | c_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * C;

    // x carries {a chunks still to be added, sum chunks already done}.
    // y carries the b_eff chunks still to be added.
    logic [WIDTH-1:0]    x_d;
    logic [WIDTH-LO-1:0] y_d;
    logic                cy_d;
    logic                v_d;
    logic [C:0]          part;
    logic [WIDTH-1:0]    x_nxt;
    logic [WIDTH-1:0]    x_q;
    logic                cy_q;
    logic                v_q;

    if (k == 0) begin : g_first
      assign x_d  = a;
      assign y_d  = b_eff;
      assign cy_d = cin_eff;
      assign v_d  = in_valid;
    end else begin : g_next
      assign x_d  = g_stage[k-1].x_q;
      assign y_d  = g_stage[k-1].g_mid.y_q;
      assign cy_d = g_stage[k-1].cy_q;
      assign v_d  = g_stage[k-1].v_q;
    end

    assign part = {1'b0, x_d[LO +: C]} + {1'b0, y_d[C-1:0]} + {{C{1'b0}}, cy_d};

    always_comb begin
      x_nxt          = x_d;
      x_nxt[LO +: C] = part[C-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments only. Otherwise a stage
    // could see its neighbour's new value within the same edge and the skew would collapse.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q  <= 1'b0;
        x_q  <= '0;
        cy_q <= 1'b0;
      end else if (en) begin
        v_q <= v_d;
        if (v_d) begin
          x_q  <= x_nxt;
          cy_q <= part[C];
        end
      end
    end

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-LO-C-1:0] y_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)             y_q <= '0;
        else if (en && v_d)  y_q <= y_d[WIDTH-LO-1:C];
      end
    end else begin : g_last
      // The top chunk holds both operand MSBs, so overflow is resolved here.
      logic ovf_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          ovf_q <= 1'b0;
        else if (en && v_d)
          ovf_q <= (x_d[WIDTH-1] == y_d[C-1]) && (part[C-1] != x_d[WIDTH-1]);
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].x_q;
  assign c_out     = g_stage[STAGES-1].cy_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: a 16-bit/4-stage instance for the vector table and
// the stream/stall/reset sequences, and a 4-bit/2-stage instance for the exhaustive sweep.
module tb_pipelined_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en;
  logic        iv16, cin16, sub16, ov16, c16, ovf16;
  logic [15:0] a16, b16, s16;
  logic        iv4, cin4, sub4, ov4, c4, ovf4;
  logic [3:0]  a4, b4, s4;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  vec_t        vecs[10];
  logic        st_v[4]   = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic [15:0] st_a[4]   = '{16'h0001, 16'h0003, 16'h0000, 16'h00FF};
  logic [15:0] st_b[4]   = '{16'h0002, 16'h0004, 16'h0000, 16'h0001};
  logic        st_ev[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic [15:0] st_es[4]  = '{16'h0003, 16'h0007, 16'h0007, 16'h0100};

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut16 (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv16), .a(a16), .b(b16),
    .c_in(cin16), .sub(sub16), .out_valid(ov16), .sum(s16), .c_out(c16), .ovf(ovf16)
  );

  pipelined_adder #(.WIDTH(4), .STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv4), .a(a4), .b(b4),
    .c_in(cin4), .sub(sub4), .out_valid(ov4), .sum(s4), .c_out(c4), .ovf(ovf4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
    iv16  = v;
    a16   = a;
    b16   = b;
    cin16 = cin;
    sub16 = sub;
  endtask

  function automatic logic [31:0] out16();
    return {13'b0, ov16, ovf16, c16, s16};
  endfunction

  function automatic logic [31:0] exp16(input logic v, input logic o, input logic c,
                                        input logic [15:0] s);
    return {13'b0, v, o, c, s};
  endfunction

  function automatic logic [5:0] model4(input int i);
    logic [3:0] a, b, be;
    logic       ci, sb;
    logic [4:0] r;
    a  = i[3:0];
    b  = i[7:4];
    ci = i[8];
    sb = i[9];
    be = sb ? ~b : b;
    if (sb) ci = 1'b1;
    r  = {1'b0, a} + {1'b0, be} + {4'b0, ci};
    return {(a[3] == be[3]) && (r[3] != a[3]), r[4], r[3:0]};
  endfunction

  // Called at a falling edge; returns at the falling edge after the result's hold cycle.
  task automatic run_one(input string name, input vec_t v);
    drive16(1'b1, v.a, v.b, v.cin, v.sub);
    @(negedge clk);
    iv16 = 1'b0;
    repeat (3) @(negedge clk);
    check(name, out16(), exp16(1'b1, v.o, v.c, v.s));
    @(negedge clk);
    check({name, "_hold"}, out16(), exp16(1'b0, v.o, v.c, v.s));
  endtask

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[6] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
    vecs[9] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst = 1'b1;
    en  = 1'b1;
    drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
    #1;
    check("reset16", out16(), exp16(1'b0, 1'b0, 1'b0, 16'h0));
    check("reset4", {ov4, ovf4, c4, s4}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, one at a time.
    for (int i = 0; i < 10; i++)
      run_one($sformatf("vec%0d", i), vecs[i]);

    // Streaming with a bubble: results arrive four edges after their inputs.
    for (int n = 0; n < 8; n++) begin
      if (n >= 4)
        check($sformatf("stream%0d", n - 4), out16(),
              exp16(st_ev[n-4], 1'b0, 1'b0, st_es[n-4]));
      if (n < 4) drive16(st_v[n], st_a[n], st_b[n], 1'b0, 1'b0);
      else       drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      @(negedge clk);
    end

    // Stall for three cycles with two operations in flight.
    drive16(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    drive16(1'b1, 16'h0100, 16'h0001, 1'b0, 1'b1);
    @(negedge clk);
    en = 1'b0;
    drive16(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall_frozen%0d", i), out16(), exp16(1'b0, 1'b0, 1'b0, 16'h0100));
    end
    en = 1'b1;
    drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("stall_resume_wait", out16(), exp16(1'b0, 1'b0, 1'b0, 16'h0100));
    @(negedge clk);
    check("stall_first", out16(), exp16(1'b1, 1'b0, 1'b0, 16'h3333));
    @(negedge clk);
    check("stall_second", out16(), exp16(1'b1, 1'b0, 1'b1, 16'h00FF));
    @(negedge clk);
    check("stall_drain", out16(), exp16(1'b0, 1'b0, 1'b1, 16'h00FF));

    // Reset with three operations in flight, preceded by a result that sets ovf.
    run_one("pre_reset", vecs[2]);
    drive16(1'b1, 16'h1000, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    drive16(1'b1, 16'h2000, 16'h0002, 1'b0, 1'b0);
    @(negedge clk);
    drive16(1'b1, 16'h3000, 16'h0003, 1'b0, 1'b0);
    @(negedge clk);
    drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 check("reset_async", out16(), exp16(1'b0, 1'b0, 1'b0, 16'h0));
    @(negedge clk);
    rst = 1'b0;
    drive16(1'b1, 16'h0003, 16'h0005, 1'b0, 1'b1);
    @(negedge clk);
    drive16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    check("post_reset_quiet0", out16(), exp16(1'b0, 1'b0, 1'b0, 16'h0));
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_reset_quiet%0d", i), out16(), exp16(1'b0, 1'b0, 1'b0, 16'h0));
    end
    @(negedge clk);
    check("post_reset_result", out16(), exp16(1'b1, 1'b0, 1'b0, 16'hFFFE));
    @(negedge clk);
    check("post_reset_hold", out16(), exp16(1'b0, 1'b0, 1'b0, 16'hFFFE));

    // Exhaustive sweep on the 4-bit/2-stage instance, one operation per cycle.
    for (int n = 0; n < 1026; n++) begin
      if (n >= 2)
        check($sformatf("exh%0d", n - 2), {ov4, ovf4, c4, s4}, {1'b1, model4(n - 2)});
      if (n < 1024) begin
        iv4 = 1'b1;
        {sub4, cin4, b4, a4} = 10'(n);
      end else begin
        iv4 = 1'b0;
      end
      @(negedge clk);
    end
    check("exh_drain", {28'b0, ov4, 3'b0}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
